// File: rtl/ps2_pkg.sv
// Shared constants, frame FSM state type and drop-list helper for the PS/2 receiver.
package ps2_pkg;

    // Prefix bytes of scan code set 2
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    // Keyboard housekeeping bytes that never map to a key
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_OVR0   = 8'h00;
    localparam logic [7:0] PS2_OVR1   = 8'hFF;

    // Fake shift codes the keyboard wraps around E0 keys
    localparam logic [7:0] PS2_FAKE_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_FAKE_RSHIFT = 8'h59;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCheck
    } frame_state_e;

    function automatic logic is_drop_code(input logic [7:0] b);
        return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_ECHO) ||
               (b == PS2_RESEND) || (b == PS2_OVR0) || (b == PS2_OVR1);
    endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Key event bus from the PS/2 receiver to the keyboard matrix.
interface ps2_scancode_rx_if;
    logic       key_strobe;
    logic       key_pressed;
    logic       key_extended;
    logic [7:0] key_code;
    logic       frame_err;

    modport master (
        output key_strobe,
        output key_pressed,
        output key_extended,
        output key_code,
        output frame_err
    );

    modport slave (
        input key_strobe,
        input key_pressed,
        input key_extended,
        input key_code,
        input frame_err
    );
endinterface

// File: rtl/ps2_filter.sv
// Two-flop synchroniser, glitch filter and falling-edge detect for one PS/2 pin.
module ps2_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic fall
);
    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, fall_q;
    logic          differ, flip;

    // Filtered level only moves after FILTER_LEN consecutive differing samples
    always_comb begin
        differ = sync_q[1] != level_q;
        flip   = differ && (cnt_q == CW'(FILTER_LEN - 1));
        cnt_d  = '0;
        if (differ && !flip) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Synchroniser, counter, filtered level and registered fall pulse; pins idle high
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], pin};
            cnt_q   <= cnt_d;
            level_q <= flip ? ~level_q : level_q;
            fall_q  <= flip && level_q;
        end
    end

    assign level = level_q;
    assign fall  = fall_q;
endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 frame receiver and scan-code-set-2 prefix folder producing single key events.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 2000
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    ps2_scancode_rx_if.master ev
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_level, clk_fall;
    logic [1:0]    data_sync_q;
    logic          data_bit;

    frame_state_e  state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shreg_q, shreg_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic [2:0]    pause_q, pause_d;
    logic          strobe_q, strobe_d, pressed_q, pressed_d, extended_q, extended_d;
    logic [7:0]    code_q, code_d;
    logic          err_q, err_d;

    logic [7:0]    rx_byte;
    logic          byte_ok;
    logic          dec_ext, dec_brk, dec_emit;
    logic [2:0]    dec_pause;

    ps2_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk  (clk),
        .reset(reset),
        .pin  (ps2_clk),
        .level(clk_level),
        .fall (clk_fall)
    );

    // Data pin only needs synchronising; the clock filter delay covers its settling
    always_ff @(posedge clk) begin
        if (reset) data_sync_q <= 2'b11;
        else       data_sync_q <= {data_sync_q[0], ps2_data};
    end
    assign data_bit = data_sync_q[1];

    // shreg holds {stop, parity, data[7:0]} once all ten bits are in
    assign rx_byte = shreg_q[7:0];
    assign byte_ok = (^shreg_q[8:0]) && shreg_q[9];

    // Prefix folding: pause swallow, prefixes, drop list, fake shifts, then emit
    always_comb begin
        dec_ext   = ext_q;
        dec_brk   = brk_q;
        dec_pause = pause_q;
        dec_emit  = 1'b0;
        if (pause_q != 3'd0) begin
            dec_pause = pause_q - 3'd1;
        end else if (rx_byte == PS2_PAUSE) begin
            dec_pause = 3'd7;
        end else if (rx_byte == PS2_EXT) begin
            dec_ext = 1'b1;
        end else if (rx_byte == PS2_BRK) begin
            dec_brk = 1'b1;
        end else if (is_drop_code(rx_byte) && !ext_q && !brk_q) begin
            dec_emit = 1'b0;
        end else if (ext_q && (rx_byte == PS2_FAKE_LSHIFT || rx_byte == PS2_FAKE_RSHIFT)) begin
            dec_ext = 1'b0;
            dec_brk = 1'b0;
        end else begin
            dec_emit = 1'b1;
            dec_ext  = 1'b0;
            dec_brk  = 1'b0;
        end
    end

    // Frame FSM next state, bit shifting, timeout and registered event outputs
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        to_cnt_d   = '0;
        ext_d      = ext_q;
        brk_d      = brk_q;
        pause_d    = pause_q;
        strobe_d   = 1'b0;
        err_d      = 1'b0;
        pressed_d  = pressed_q;
        extended_d = extended_q;
        code_d     = code_q;
        unique case (state_q)
            StIdle: begin
                if (clk_fall) begin
                    if (!data_bit) begin
                        state_d   = StShift;
                        bit_cnt_d = 4'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StShift: begin
                if (clk_fall) begin
                    shreg_d   = {data_bit, shreg_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) state_d = StCheck;
                end else if (clk_level) begin
                    if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_d = StIdle;
                        err_d   = 1'b1;
                        ext_d   = 1'b0;
                        brk_d   = 1'b0;
                        pause_d = 3'd0;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end else begin
                    to_cnt_d = to_cnt_q;
                end
            end
            StCheck: begin
                state_d = StIdle;
                if (!byte_ok) begin
                    err_d   = 1'b1;
                    ext_d   = 1'b0;
                    brk_d   = 1'b0;
                    pause_d = 3'd0;
                end else begin
                    ext_d   = dec_ext;
                    brk_d   = dec_brk;
                    pause_d = dec_pause;
                    if (dec_emit) begin
                        strobe_d   = 1'b1;
                        code_d     = rx_byte;
                        extended_d = ext_q;
                        pressed_d  = ~brk_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset drops any partial frame silently
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 4'd0;
            shreg_q    <= '0;
            to_cnt_q   <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            pause_q    <= 3'd0;
            strobe_q   <= 1'b0;
            pressed_q  <= 1'b0;
            extended_q <= 1'b0;
            code_q     <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            to_cnt_q   <= to_cnt_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            pause_q    <= pause_d;
            strobe_q   <= strobe_d;
            pressed_q  <= pressed_d;
            extended_q <= extended_d;
            code_q     <= code_d;
            err_q      <= err_d;
        end
    end

    assign ev.key_strobe   = strobe_q;
    assign ev.key_pressed  = pressed_q;
    assign ev.key_extended = extended_q;
    assign ev.key_code     = code_q;
    assign ev.frame_err    = err_q;
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: directed PS/2 frames, queued expected events.
module tb_ps2_scancode_rx;
    localparam int unsigned FILTER_LEN     = 8;
    localparam int unsigned TIMEOUT_CYCLES = 2000;
    localparam int unsigned HALF           = 40;

    typedef struct packed {
        logic       pressed;
        logic       ext;
        logic [7:0] code;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail = 0;
    int  err_seen = 0;
    int  err_exp = 0;

    ps2_scancode_rx_if ev ();

    ps2_scancode_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .ev      (ev)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: pop and compare on every strobe, count error pulses
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (ev.frame_err) err_seen++;
                if (ev.key_strobe) begin
                    check("strobe_err_exclusive", {31'd0, ev.frame_err}, 32'd0);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_strobe: got code %0h, required no strobe",
                                 ev.key_code);
                    end else begin
                        e = exp_q.pop_front();
                        check("event", {22'd0, ev.key_pressed, ev.key_extended, ev.key_code},
                              {22'd0, e});
                    end
                end
            end
        end
    end

    // Bits are LSB first; data changes mid-high, sampled by the DUT on clock fall
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        ps2_data = 1'b1;
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input logic bad_par);
        logic par;
        par = (~^b) ^ bad_par;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        send_bits(frame(b, 1'b0), 11);
    endtask

    task automatic expect_ev(input logic pressed, input logic ext, input logic [7:0] code);
        ev_t e;
        e.pressed = pressed;
        e.ext     = ext;
        e.code    = code;
        exp_q.push_back(e);
    endtask

    task automatic checkpoint(input string name);
        repeat (60) @(negedge clk);
        check({name, "_pending"}, exp_q.size(), 0);
        check({name, "_errs"}, err_seen, err_exp);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_strobe"}, {31'd0, ev.key_strobe}, 32'd0);
        check({name, "_pressed"}, {31'd0, ev.key_pressed}, 32'd0);
        check({name, "_extended"}, {31'd0, ev.key_extended}, 32'd0);
        check({name, "_code"}, {24'd0, ev.key_code}, 32'd0);
        check({name, "_err"}, {31'd0, ev.frame_err}, 32'd0);
    endtask

    initial begin
        logic [7:0] pause_seq [8];
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Plain make
        expect_ev(1'b1, 1'b0, 8'h1C);
        send_byte(8'h1C);
        checkpoint("make_1c");

        // Break prefix alone, then break
        send_byte(8'hF0);
        checkpoint("f0_alone");
        expect_ev(1'b0, 1'b0, 8'h1C);
        send_byte(8'h1C);
        checkpoint("break_1c");

        // Extended break, then fake shift
        expect_ev(1'b0, 1'b1, 8'h75);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        checkpoint("ext_break_75");
        send_byte(8'hE0);
        send_byte(8'h12);
        checkpoint("fake_shift");

        // Housekeeping byte dropped
        send_byte(8'hAA);
        checkpoint("bat_drop");

        // Pause sequence swallowed, following key decodes
        for (int i = 0; i < 8; i++) send_byte(pause_seq[i]);
        expect_ev(1'b1, 1'b0, 8'h29);
        send_byte(8'h29);
        checkpoint("pause_then_29");

        // Parity error
        err_exp++;
        send_bits(frame(8'h1C, 1'b1), 11);
        checkpoint("parity_err");

        // Timeout after four bits, then recovery
        send_bits(frame(8'h29, 1'b0), 4);
        repeat (TIMEOUT_CYCLES + 300) @(negedge clk);
        err_exp++;
        checkpoint("timeout");
        expect_ev(1'b1, 1'b0, 8'h29);
        send_byte(8'h29);
        checkpoint("after_timeout");

        // Short clock glitch must not register as a start bit
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        checkpoint("glitch");
        expect_ev(1'b1, 1'b0, 8'h5A);
        send_byte(8'h5A);
        checkpoint("after_glitch");

        // Reset mid-frame
        send_bits(frame(8'h1C, 1'b0), 5);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("midframe_reset");
        reset = 1'b0;
        repeat (10) @(negedge clk);
        expect_ev(1'b1, 1'b0, 8'h16);
        send_byte(8'h16);
        checkpoint("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
